// File: rtl/rv32i_execute_block_if.sv
// Decode-to-execute and execute-to-writeback bus of the RV32I execute stage.
interface rv32i_execute_block_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int PC_WIDTH       = 6
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                alu_op;
  logic [REGISTER_WIDTH-1:0] rs1_data;
  logic [REGISTER_WIDTH-1:0] rs2_data;
  logic [REGISTER_WIDTH-1:0] imm;
  logic                      use_imm;
  logic [4:0]                rd_num;
  logic                      rd_we;
  logic [PC_WIDTH-1:0]       pc_in;
  logic                      is_branch;
  logic [2:0]                br_funct3;
  logic                      out_valid;
  logic                      out_ready;
  logic [REGISTER_WIDTH-1:0] result_o;
  logic [4:0]                rd_num_o;
  logic                      rd_we_o;
  logic                      branch_taken_o;
  logic [PC_WIDTH-1:0]       branch_target_o;

  modport master (
    output in_valid, alu_op, rs1_data, rs2_data, imm, use_imm, rd_num, rd_we,
           pc_in, is_branch, br_funct3, out_ready,
    input  in_ready, out_valid, result_o, rd_num_o, rd_we_o, branch_taken_o,
           branch_target_o
  );

  modport slave (
    input  in_valid, alu_op, rs1_data, rs2_data, imm, use_imm, rd_num, rd_we,
           pc_in, is_branch, br_funct3, out_ready,
    output in_ready, out_valid, result_o, rd_num_o, rd_we_o, branch_taken_o,
           branch_target_o
  );
endinterface

// File: rtl/rv32i_execute_block.sv
// RV32I execute stage: single-cycle ALU/branch resolve, shifts done
// serially one bit per cycle, valid/ready on both sides.
module rv32i_execute_block #(
  parameter int REGISTER_WIDTH = 32,
  parameter int PC_WIDTH       = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  flush,
  rv32i_execute_block_if.slave bus
);
  localparam int W = REGISTER_WIDTH;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nx;
  logic [W-1:0]        res_q;
  logic [4:0]          rd_q;
  logic                we_q, tk_q;
  logic [PC_WIDTH-1:0] tgt_q;
  logic [4:0]          cnt;
  logic [3:0]          sh_op;

  logic [W-1:0] opb, alu_res;
  logic [4:0]   shamt;
  logic         br_take, is_shift, start_shift, accept;

  assign opb         = bus.use_imm ? bus.imm : bus.rs2_data;
  assign shamt       = opb[4:0];
  assign is_shift    = !bus.is_branch &&
                       (bus.alu_op == 4'd2 || bus.alu_op == 4'd6 || bus.alu_op == 4'd7);
  assign start_shift = is_shift && (shamt != 5'd0);
  // flush wins over a handshake that happens in the same cycle
  assign accept      = bus.in_valid && bus.in_ready && !flush;

  assign bus.in_ready        = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid       = (state == DONE);
  assign bus.result_o        = res_q;
  assign bus.rd_num_o        = rd_q;
  assign bus.rd_we_o         = we_q;
  assign bus.branch_taken_o  = tk_q;
  assign bus.branch_target_o = tgt_q;

  // Single-cycle ALU; shift codes pass A through (shamt 0 or serial preload)
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'd0:    alu_res = bus.rs1_data + opb;
      4'd1:    alu_res = bus.rs1_data - opb;
      4'd3:    alu_res = {{(W-1){1'b0}}, $signed(bus.rs1_data) < $signed(opb)};
      4'd4:    alu_res = {{(W-1){1'b0}}, bus.rs1_data < opb};
      4'd5:    alu_res = bus.rs1_data ^ opb;
      4'd8:    alu_res = bus.rs1_data | opb;
      4'd9:    alu_res = bus.rs1_data & opb;
      4'd10:   alu_res = opb;
      4'd2, 4'd6, 4'd7: alu_res = bus.rs1_data;
      default: alu_res = '0;
    endcase
  end

  // Branch condition always uses rs2, never the immediate
  always_comb begin
    br_take = 1'b0;
    case (bus.br_funct3)
      3'b000:  br_take = (bus.rs1_data == bus.rs2_data);
      3'b001:  br_take = (bus.rs1_data != bus.rs2_data);
      3'b100:  br_take = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      3'b101:  br_take = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      3'b110:  br_take = (bus.rs1_data <  bus.rs2_data);
      3'b111:  br_take = (bus.rs1_data >= bus.rs2_data);
      default: br_take = 1'b0;
    endcase
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == 5'd1) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = accept ? (start_shift ? SHIFT : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // State register, operand capture and the serial shifter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      rd_q  <= '0;
      we_q  <= 1'b0;
      tk_q  <= 1'b0;
      tgt_q <= '0;
      cnt   <= '0;
      sh_op <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rd_q  <= bus.rd_num;
        we_q  <= bus.rd_we && !bus.is_branch;
        tk_q  <= bus.is_branch && br_take;
        tgt_q <= bus.is_branch ? bus.pc_in + bus.imm[PC_WIDTH-1:0] : '0;
        res_q <= bus.is_branch ? '0 : alu_res;
        cnt   <= start_shift ? shamt : 5'd0;
        sh_op <= bus.alu_op;
      end else if (flush) begin
        cnt <= '0;
      end else if (state == SHIFT) begin
        case (sh_op)
          4'd2:    res_q <= {res_q[W-2:0], 1'b0};
          4'd6:    res_q <= {1'b0, res_q[W-1:1]};
          default: res_q <= {res_q[W-1], res_q[W-1:1]};
        endcase
        cnt <= cnt - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_execute_block.sv
// Directed bench for rv32i_execute_block with an expected-result queue.
module tb_rv32i_execute_block;
  logic clk = 1'b0;
  logic rst_n, flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv32i_execute_block_if #(.REGISTER_WIDTH(32), .PC_WIDTH(6)) bus ();

  rv32i_execute_block #(.REGISTER_WIDTH(32), .PC_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        tk;
    logic [5:0]  tgt;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one op at the current negedge; optionally push its expected output
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ui, input logic [4:0] rd,
                       input logic we, input logic [5:0] pc, input logic br,
                       input logic [2:0] f3, input bit push);
    exp_t e;
    logic [31:0] bb;
    bb = ui ? im : b;
    e.rd = rd;
    if (br) begin
      e.res = '0; e.we = 1'b0; e.tk = br_model(f3, a, b); e.tgt = pc + im[5:0];
    end else begin
      e.res = alu_model(op, a, bb); e.we = we; e.tk = 1'b0; e.tgt = '0;
    end
    if (push) sbq.push_back(e);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.rs1_data = a; bus.rs2_data = b;
    bus.imm = im; bus.use_imm = ui; bus.rd_num = rd; bus.rd_we = we;
    bus.pc_in = pc; bus.is_branch = br; bus.br_funct3 = f3;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sbq_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_result"}, bus.result_o, e.res);
      chk({tag, "_rd"}, {27'd0, bus.rd_num_o}, {27'd0, e.rd});
      chk({tag, "_we"}, {31'd0, bus.rd_we_o}, {31'd0, e.we});
      chk({tag, "_taken"}, {31'd0, bus.branch_taken_o}, {31'd0, e.tk});
      chk({tag, "_target"}, {26'd0, bus.branch_target_o}, {26'd0, e.tgt});
    end
  endtask

  // Full transaction with out_ready high: accept, latency, stall count, result, return to IDLE
  task automatic run_one(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic ui,
                         input logic [4:0] rd, input logic we, input logic [5:0] pc,
                         input logic br, input logic [2:0] f3);
    int lat, lowc, exp_lat;
    logic [31:0] bb;
    bb = ui ? im : b;
    exp_lat = (!br && (op == 4'd2 || op == 4'd6 || op == 4'd7)) ? int'(bb[4:0]) + 1 : 1;
    bus.out_ready = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    issue(op, a, b, im, ui, rd, we, pc, br, f3, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; lowc = 0;
    forever begin
      if (!bus.in_ready) lowc++;
      if (bus.out_valid || lat > 200) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_stall"}, lowc, exp_lat - 1);
    compare_out(tag);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.alu_op = '0; bus.rs1_data = '0;
    bus.rs2_data = '0; bus.imm = '0; bus.use_imm = 1'b0; bus.rd_num = '0; bus.rd_we = 1'b0;
    bus.pc_in = '0; bus.is_branch = 1'b0; bus.br_funct3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_rd", {27'd0, bus.rd_num_o}, 32'd0);
    chk("rst_we", {31'd0, bus.rd_we_o}, 32'd0);
    chk("rst_taken", {31'd0, bus.branch_taken_o}, 32'd0);
    chk("rst_target", {26'd0, bus.branch_target_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_one("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd9, 32'd1, 1'b1, 5'd3, 1'b1, 6'd0, 1'b0, 3'd0);
    run_one("sra", 4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 5'd4, 1'b1, 6'd0, 1'b0, 3'd0);
    run_one("blt", 4'd0, 32'hFFFF_FFFE, 32'd1, 32'd8, 1'b1, 5'd7, 1'b1, 6'd60, 1'b1, 3'b100);
    run_one("beq", 4'd0, 32'd5, 32'd5, 32'hFFFF_FFFC, 1'b1, 5'd1, 1'b1, 6'd2, 1'b1, 3'b000);
    run_one("bne_nt", 4'd0, 32'd5, 32'd5, 32'd4, 1'b0, 5'd1, 1'b0, 6'd2, 1'b1, 3'b001);
    run_one("bge", 4'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd2, 1'b1, 6'd10, 1'b1, 3'b101);
    run_one("bltu_nt", 4'd0, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b1, 5'd2, 1'b1, 6'd10, 1'b1, 3'b110);
    run_one("bgeu", 4'd0, 32'hFFFF_FFFE, 32'd1, 32'd3, 1'b1, 5'd2, 1'b1, 6'd10, 1'b1, 3'b111);
    run_one("br_f3_010", 4'd0, 32'd1, 32'd1, 32'd3, 1'b1, 5'd2, 1'b1, 6'd10, 1'b1, 3'b010);
    run_one("br_f3_011", 4'd0, 32'd1, 32'd1, 32'd3, 1'b1, 5'd2, 1'b1, 6'd10, 1'b1, 3'b011);
    run_one("slt_neg", 4'd3, 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b0, 5'd5, 1'b1, 6'd0, 1'b0, 3'd0);
    run_one("sltu_neg", 4'd4, 32'hFFFF_FFFB, 32'd3, 32'd0, 1'b0, 5'd5, 1'b1, 6'd0, 1'b0, 3'd0);
    run_one("srl_sh0", 4'd6, 32'h8000_00F3, 32'd7, 32'h0000_0020, 1'b1, 5'd6, 1'b1, 6'd0, 1'b0, 3'd0);
    for (int op = 0; op < 16; op++)
      run_one($sformatf("sweep%0d", op), 4'(op), 32'h8000_00F3, 32'h0000_0003, 32'd0, 1'b0,
              5'(op), 1'b1, 6'd0, 1'b0, 3'd0);

    // back-pressure: SUB held for 3 cycles, a pending AND must wait
    bus.out_ready = 1'b0;
    issue(4'd1, 32'd5, 32'd7, 32'd0, 1'b0, 5'd9, 1'b1, 6'd0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    compare_out("bp_sub");
    issue(4'd9, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'd0, 1'b0, 5'd10, 1'b1, 6'd0, 1'b0, 3'd0, 1'b1);
    chk("bp_in_ready0", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_result", bus.result_o, 32'hFFFF_FFFE);
      chk("bp_hold_rd", {27'd0, bus.rd_num_o}, 32'd9);
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_and_valid", {31'd0, bus.out_valid}, 32'd1);
    compare_out("bp_and");
    @(negedge clk);
    chk("bp_idle", {31'd0, bus.out_valid}, 32'd0);

    // back-to-back XOR then OR
    issue(4'd5, 32'h1234_5678, 32'hFFFF_0000, 32'd0, 1'b0, 5'd11, 1'b1, 6'd0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    chk("b2b_xor_valid", {31'd0, bus.out_valid}, 32'd1);
    compare_out("b2b_xor");
    issue(4'd8, 32'h1234_5678, 32'h0000_0F0F, 32'd0, 1'b0, 5'd12, 1'b1, 6'd0, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_or_valid", {31'd0, bus.out_valid}, 32'd1);
    compare_out("b2b_or");
    @(negedge clk);
    chk("b2b_idle", {31'd0, bus.out_valid}, 32'd0);

    // flush in IDLE beats a same-cycle handshake
    issue(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd1, 1'b1, 6'd0, 1'b0, 3'd0, 1'b0);
    flush = 1'b1;
    chk("flush_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_idle_no_capture", {31'd0, bus.out_valid}, 32'd0);

    // flush during SLL shamt=20 at cycle 3
    issue(4'd2, 32'd1, 32'd0, 32'd20, 1'b1, 5'd2, 1'b1, 6'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    chk("flush_shift_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_shift_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_shift_idle", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (30) begin @(negedge clk); if (bus.out_valid) seen++; end
    chk("flush_never_valid", seen, 0);

    // reset during SLL shamt=20 at cycle 3
    issue(4'd2, 32'd1, 32'd0, 32'd20, 1'b1, 5'd2, 1'b1, 6'd0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_shift_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_shift_result", bus.result_o, 32'd0);
    @(negedge clk);
    chk("rst_shift_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (30) begin @(negedge clk); if (bus.out_valid) seen++; end
    chk("rst_never_valid", seen, 0);

    run_one("after_rst_add", 4'd0, 32'd100, 32'd23, 32'd0, 1'b0, 5'd31, 1'b1, 6'd0, 1'b0, 3'd0);
    chk("sbq_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_execute_block.md
RV32I_EXECUTE_BLOCK -- requirements
Module: rv32i_execute_block

Interface
REQ-001 The block SHALL have parameter REGISTER_WIDTH, default 32: operand/result width.
REQ-002 The block SHALL have parameter PC_WIDTH, default 6: program-counter width, matching the fetch PC.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on rising clk.
REQ-005 The block SHALL have port flush, input, 1: discard in-flight op and output.
REQ-006 The block SHALL have port in_valid / in_ready, input / output, 1 each: decode-to-execute handshake.
REQ-007 The block SHALL have port alu_op, input, 4: operation code.
REQ-008 The block SHALL have ports rs1_data / rs2_data / imm, input, REGISTER_WIDTH each: operands and sign-extended immediate.
REQ-009 The block SHALL have port use_imm, input, 1: operand B = imm when 1, else rs2_data.
REQ-010 The block SHALL have ports rd_num, input, 5, and rd_we, input, 1: destination register and write enable.
REQ-011 The block SHALL have ports pc_in, input, PC_WIDTH; is_branch, input, 1; br_funct3, input, 3.
REQ-012 The block SHALL have port out_valid / out_ready, output / input, 1 each: execute-to-writeback handshake.
REQ-013 The block SHALL have outputs result_o (REGISTER_WIDTH), rd_num_o (5), rd_we_o (1), branch_taken_o (1) and branch_target_o (PC_WIDTH).

Function
REQ-014 alu_op encodings SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B; codes 11-15 SHALL yield result 0.
REQ-015 Arithmetic SHALL be modulo 2^REGISTER_WIDTH with overflow discarded; SLT is signed, SLTU unsigned, and both give 0 or 1.
REQ-016 Shift amount SHALL be operand B[4:0]; SRA SHALL replicate the sign bit.
REQ-017 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-018 A transfer SHALL occur when in_valid and in_ready are both high at a rising edge; all inputs SHALL be captured at that edge.
REQ-019 in_ready SHALL be high in IDLE, high in DONE when out_ready is high, and low in SHIFT.
REQ-020 Non-shift op, or shift with shamt 0: the FSM SHALL go to DONE, with out_valid high exactly 1 cycle after accept.
REQ-021 Shift with shamt N>0: the FSM SHALL enter SHIFT and shift 1 bit per cycle; out_valid SHALL rise N+1 cycles after accept.
REQ-022 In DONE, result_o, rd_num_o, rd_we_o, branch_taken_o and branch_target_o SHALL stay stable until out_valid && out_ready.
REQ-023 DONE with out_ready high and in_valid high SHALL accept the new op in the same cycle (back-to-back, no bubble).
REQ-024 DONE with out_ready high and in_valid low SHALL go to IDLE with out_valid low next cycle.
REQ-025 is_branch=1 SHALL compare rs1_data with rs2_data, ignoring use_imm, by br_funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
REQ-026 br_funct3 values 010 and 011 SHALL give not-taken.
REQ-027 A branch SHALL force rd_we_o=0 and result_o=0, and set branch_target_o = pc_in + imm[PC_WIDTH-1:0] (wrap-around).
REQ-028 Non-branch ops SHALL set branch_taken_o=0 and branch_target_o=0.
REQ-029 flush SHALL take priority over accept: next cycle state IDLE, out_valid 0, and no capture that cycle even if in_valid.
REQ-030 in_ready SHALL still follow REQ-019 during flush.

Reset
REQ-031 rst_n low at an edge SHALL set: state IDLE; out_valid, branch_taken_o and rd_we_o to 0; result_o, rd_num_o and branch_target_o to 0; the shift counter to 0.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abandon the op with no output transfer.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-034 The bench SHALL cover ADD: rs1=0xFFFFFFFF, imm=1, use_imm=1 -> result_o=0x00000000, out_valid 1 cycle after accept.
REQ-035 The bench SHALL cover SRA: rs1=0x80000000, rs2=4 -> out_valid 5 cycles after accept, result_o=0xF8000000, in_ready low for 4 cycles.
REQ-036 The bench SHALL cover BLT: rs1=0xFFFFFFFE, rs2=1, pc_in=60, imm=8 -> branch_taken_o=1, branch_target_o=4, rd_we_o=0.
REQ-037 The bench SHALL cover back-pressure: out_ready low for 3 cycles on a SUB 5-7 -> result_o held at 0xFFFFFFFE; no new accept until drained.
REQ-038 The bench SHALL cover back-to-back XOR then OR, with in_valid and out_ready held high -> one out_valid per cycle with no bubble.
REQ-039 The bench SHALL cover flush during SLL shamt=20 at cycle 3 -> out_valid never rises for that op and state is IDLE next cycle; reset mid-SHIFT gives the same result.
